// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and status widths for the video PLL lock supervisor.
package pll_lock_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2,
        ST_PLLRST = 2'd3
    } state_t;

    localparam int LOSS_W  = 8;
    localparam int RETRY_W = 4;

    localparam logic [LOSS_W-1:0]  LOSS_MAX  = '1;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchronizer for a single-bit level crossing into clk.
module sync_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Filters the video PLL lock flag into a clean video reset and retries the PLL on lock timeout.
//
//   state     | meaning
//   ST_WAIT   | reset asserted, waiting for lock_s to stay high long enough
//   ST_HOLD   | lock stable, holding reset for the fixed hold time
//   ST_RUN    | video logic released (rst_n_o = ready_o = 1)
//   ST_PLLRST | lock timed out, pulsing pll_rst_o
module pll_lock_supervisor
    import pll_lock_supervisor_pkg::*;
#(
    parameter int LOCK_STABLE   = 1024,
    parameter int RESET_HOLD    = 256,
    parameter int LOCK_TIMEOUT  = 2500000,
    parameter int PLLRST_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked_i,
    output logic               pll_rst_o,
    output logic               rst_n_o,
    output logic               ready_o,
    output logic [LOSS_W-1:0]  loss_cnt_o,
    output logic [RETRY_W-1:0] retry_cnt_o
);

    localparam int STAB_W   = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
    localparam int TMO_W    = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int HOLD_MAX = (RESET_HOLD > PLLRST_CYCLES) ? RESET_HOLD : PLLRST_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [STAB_W-1:0] STAB_LAST   = STAB_W'(LOCK_STABLE - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] PLLRST_LAST = HOLD_W'(PLLRST_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic                lock_s;
    logic [STAB_W-1:0]   stab_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                stab_done;
    logic                tmo_done;

    sync_ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked_i),
        .q     (lock_s)
    );

    assign stab_done = lock_s && (stab_cnt == STAB_LAST);
    assign tmo_done  = (tmo_cnt == TMO_LAST);
    assign ready_o   = rst_n_o;

    // Stable lock takes priority over a timeout landing on the same edge.
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: begin
                if (stab_done)     state_next = ST_HOLD;
                else if (tmo_done) state_next = ST_PLLRST;
            end
            ST_HOLD: begin
                if (!lock_s)                    state_next = ST_WAIT;
                else if (hold_cnt == HOLD_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) state_next = ST_WAIT;
            end
            ST_PLLRST: begin
                if (hold_cnt == PLLRST_LAST) state_next = ST_WAIT;
            end
            default: state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_WAIT;
            stab_cnt    <= '0;
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
            rst_n_o     <= 1'b0;
            pll_rst_o   <= 1'b0;
            loss_cnt_o  <= '0;
            retry_cnt_o <= '0;
        end else begin
            state     <= state_next;
            rst_n_o   <= (state_next == ST_RUN);
            pll_rst_o <= (state_next == ST_PLLRST);

            // Any state change restarts every timer; only the entered state's timers matter.
            if (state_next != state) begin
                stab_cnt <= '0;
                tmo_cnt  <= '0;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_WAIT: begin
                        stab_cnt <= lock_s ? stab_cnt + 1'b1 : '0;
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
                    ST_HOLD, ST_PLLRST: hold_cnt <= hold_cnt + 1'b1;
                    default: ;
                endcase
            end

            if (state == ST_RUN && !lock_s && loss_cnt_o != LOSS_MAX)
                loss_cnt_o <= loss_cnt_o + 1'b1;

            if (state == ST_WAIT && !stab_done && tmo_done && retry_cnt_o != RETRY_MAX)
                retry_cnt_o <= retry_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized lock patterns against an edge-counting reference model of the supervisor.
module tb_pll_lock_supervisor;

    localparam int LS = 16;
    localparam int RH = 8;
    localparam int LT = 100;
    localparam int PC = 4;

    localparam int P_WAIT   = 0;
    localparam int P_HOLD   = 1;
    localparam int P_RUN    = 2;
    localparam int P_PLLRST = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked_i = 1'b0;
    logic       pll_rst_o;
    logic       rst_n_o;
    logic       ready_o;
    logic [7:0] loss_cnt_o;
    logic [3:0] retry_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, edges spent in phase, consecutive high samples since entering WAIT.
    bit [1:0] m_pipe;
    int       m_ph, m_elapsed, m_high, m_loss, m_retry;

    pll_lock_supervisor #(
        .LOCK_STABLE   (LS),
        .RESET_HOLD    (RH),
        .LOCK_TIMEOUT  (LT),
        .PLLRST_CYCLES (PC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked_i (pll_locked_i),
        .pll_rst_o    (pll_rst_o),
        .rst_n_o      (rst_n_o),
        .ready_o      (ready_o),
        .loss_cnt_o   (loss_cnt_o),
        .retry_cnt_o  (retry_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pipe = 2'b00; m_ph = P_WAIT; m_elapsed = 0; m_high = 0; m_loss = 0; m_retry = 0;
    endtask

    task automatic m_go(input int ph);
        m_ph = ph; m_elapsed = 0; m_high = 0;
    endtask

    task automatic m_edge(input bit lk);
        bit ls;
        ls = m_pipe[1];
        m_pipe = {m_pipe[0], lk};
        case (m_ph)
            P_WAIT: begin
                m_elapsed++;
                m_high = ls ? m_high + 1 : 0;
                if (m_high == LS) m_go(P_HOLD);
                else if (m_elapsed == LT) begin
                    m_go(P_PLLRST);
                    if (m_retry < 15) m_retry++;
                end
            end
            P_HOLD: begin
                if (!ls) m_go(P_WAIT);
                else begin
                    m_elapsed++;
                    if (m_elapsed == RH) m_go(P_RUN);
                end
            end
            P_RUN: begin
                if (!ls) begin
                    m_go(P_WAIT);
                    if (m_loss < 255) m_loss++;
                end
            end
            default: begin
                m_elapsed++;
                if (m_elapsed == PC) m_go(P_WAIT);
            end
        endcase
    endtask

    task automatic check_all();
        chk("pll_rst_o", pll_rst_o, m_ph == P_PLLRST);
        chk("rst_n_o", rst_n_o, m_ph == P_RUN);
        chk("ready_o", ready_o, m_ph == P_RUN);
        chk("loss_cnt_o", loss_cnt_o, m_loss);
        chk("retry_cnt_o", retry_cnt_o, m_retry);
    endtask

    task automatic cyc(input bit v);
        pll_locked_i = v;
        @(posedge clk);
        m_edge(v);
        #1;
        check_all();
    endtask

    task automatic cycs(input bit v, input int n);
        for (int i = 0; i < n; i++) cyc(v);
    endtask

    // Asserts rst_n between edges, checks outputs clear at once, then releases before the next edge.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_pll_rst_o"}, pll_rst_o, 0);
        chk({tag, "_rst_n_o"}, rst_n_o, 0);
        chk({tag, "_ready_o"}, ready_o, 0);
        chk({tag, "_loss"}, loss_cnt_o, 0);
        chk({tag, "_retry"}, retry_cnt_o, 0);
        m_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int len;
        bit lvl;
        m_reset();
        do_reset("por");

        // Steady lock from release: video reset releases after edge 2+16+8.
        cycs(1, 25);
        chk("acq_e25_rst_n_o", rst_n_o, 0);
        cyc(1);
        chk("acq_e26_rst_n_o", rst_n_o, 1);
        chk("acq_e26_ready_o", ready_o, 1);
        cycs(1, 10);

        // One-cycle glitch on the input, seen by the FSM at edge 15; release 24 edges later.
        do_reset("glitch");
        cycs(1, 12);
        cyc(0);
        cycs(1, 25);
        chk("glitch_e38_rst_n_o", rst_n_o, 0);
        cyc(1);
        chk("glitch_e39_rst_n_o", rst_n_o, 1);

        // Lock loss in RUN for 3 cycles, then reacquire.
        cycs(1, 5);
        cyc(0);
        chk("loss_k_rst_n_o", rst_n_o, 1);
        cyc(0);
        chk("loss_k1_rst_n_o", rst_n_o, 1);
        cyc(0);
        chk("loss_k2_rst_n_o", rst_n_o, 0);
        chk("loss_k2_cnt", loss_cnt_o, 1);
        cycs(1, 25);
        chk("reacq_25_rst_n_o", rst_n_o, 0);
        cyc(1);
        chk("reacq_26_rst_n_o", rst_n_o, 1);

        // Many short losses with random drop/return lengths: counter saturates.
        for (int i = 0; i < 300; i++) begin
            cycs(0, $urandom_range(1, 3));
            cycs(1, $urandom_range(26, 40));
        end
        chk("loss_saturated", loss_cnt_o, 255);

        // Random lock waveform, cycle-checked against the model.
        lvl = 1'b0;
        for (int i = 0; i < 60; i++) begin
            len = $urandom_range(1, 60);
            cycs(lvl, len);
            lvl = ~lvl;
        end

        // Timeout with lock held low: pulse after edge 100 for 4 cycles.
        do_reset("tmo");
        cycs(0, 99);
        chk("tmo_e99_pll_rst_o", pll_rst_o, 0);
        cyc(0);
        chk("tmo_e100_pll_rst_o", pll_rst_o, 1);
        chk("tmo_e100_retry", retry_cnt_o, 1);
        cycs(0, 3);
        chk("tmo_e103_pll_rst_o", pll_rst_o, 1);
        cyc(0);
        chk("tmo_e104_pll_rst_o", pll_rst_o, 0);
        cycs(0, 17 * (LT + PC));
        chk("retry_saturated", retry_cnt_o, 15);

        // Reset in the middle of a PLL reset pulse.
        do_reset("pre_pllrst");
        cycs(0, 101);
        chk("mid_pllrst_pll_rst_o", pll_rst_o, 1);
        chk("mid_pllrst_retry", retry_cnt_o, 1);
        do_reset("in_pllrst");

        // Reset while holding after stable lock.
        cycs(1, 20);
        chk("in_hold_rst_n_o", rst_n_o, 0);
        do_reset("in_hold");
        cycs(1, 30);
        chk("after_hold_reset_rst_n_o", rst_n_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Consumes the asynchronous `locked` flag of the ULX3S video PLL and turns it into a clean, filtered video-domain reset plus a PLL reset request. Runs on the 25 MHz board clock that also feeds the PLL input. It waits for lock to be stable, holds reset for a fixed time, reasserts reset on lock loss, and pulses the PLL `RST` input if lock is not reached within a timeout. It sits between the video PLL wrapper and the pixel/serializer reset synchronizers, and exposes lock-loss and retry counters as status.

## Interface
- `LOCK_STABLE`, 1024: consecutive cycles `lock_s` must be high before hold starts (≥1).
- `RESET_HOLD`, 256: cycles reset stays asserted after stable lock (≥1).
- `LOCK_TIMEOUT`, 2500000: cycles allowed in WAIT before a PLL reset (100 ms @ 25 MHz; > `LOCK_STABLE`).
- `PLLRST_CYCLES`, 16: width of the `pll_rst_o` pulse (≥1).
- `clk`  in  1  25 MHz board clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `pll_locked_i`  in  1  PLL `LOCK`, asynchronous to `clk`.
- `pll_rst_o`  out  1  active-high PLL reset request.
- `rst_n_o`  out  1  active-low reset for video logic; asserts asynchronously in the destination, destination re-synchronizes release.
- `ready_o`  out  1  high when in RUN (equals `rst_n_o`).
- `loss_cnt_o`  out  8  lock losses while in RUN, saturating at 255.
- `retry_cnt_o`  out  4  PLL resets issued by timeout, saturating at 15.

## Operation
- Clock and reset: one clock `clk`; reset is asynchronous and active-low (`rst_n`).
- `pll_locked_i` passes through a 2-FF synchronizer → `lock_s`. Nothing else samples `pll_locked_i`.
- States: WAIT, HOLD, RUN, PLLRST. Reset state WAIT.
- WAIT: `stab_cnt` increments on each edge with `lock_s`=1, clears to 0 on `lock_s`=0. When `lock_s`=1 and `stab_cnt`==`LOCK_STABLE`-1 → HOLD. `tmo_cnt` increments every cycle; at `tmo_cnt`==`LOCK_TIMEOUT`-1 without a HOLD transition → PLLRST, `retry_cnt_o`++ (saturating). HOLD transition wins over timeout on the same edge.
- HOLD: `hold_cnt` increments; `lock_s`=0 → WAIT (no loss count). At `hold_cnt`==`RESET_HOLD`-1 with `lock_s`=1 → RUN.
- RUN: `rst_n_o`=1. `lock_s`=0 on any edge → WAIT, `loss_cnt_o`++ (saturating). A single sampled low cycle counts as a loss.
- PLLRST: `pll_rst_o`=1; `hold_cnt` counts `PLLRST_CYCLES`, then → WAIT. `lock_s` ignored in PLLRST.
- Every entry into WAIT clears `stab_cnt` and `tmo_cnt`; every entry into HOLD/PLLRST clears `hold_cnt`.
- Counters sized `$clog2` of their largest parameter; no wrap is reachable.
- `rst_n` assertion mid-operation: all outputs return to reset values immediately; counters clear.

## Timing
- Reset values: `pll_rst_o`=0, `rst_n_o`=0, `ready_o`=0, `loss_cnt_o`=0, `retry_cnt_o`=0.
- All outputs registered, updated on the same edge as the state.
- Lock acquisition: with `pll_locked_i` high before edge 1 and steady, state is HOLD after edge 2+`LOCK_STABLE` and `rst_n_o` rises after edge 2+`LOCK_STABLE`+`RESET_HOLD`.
- Lock loss: `pll_locked_i` low before edge k → `rst_n_o` low after edge k+2 (synchronizer + 1 state edge); `loss_cnt_o` updates on the same edge.
- Timeout: `pll_rst_o` rises after edge `LOCK_TIMEOUT` of WAIT, stays high exactly `PLLRST_CYCLES` cycles.

## Structure
- Package `pll_lock_supervisor_pkg`: state enum (WAIT, HOLD, RUN, PLLRST), counter width constants for the status outputs.
- One sub-module: `sync_ff` (2-FF synchronizer, async active-low reset to 0), reused by other CDC points in the SoC.

## Test plan
Params `LOCK_STABLE`=16, `RESET_HOLD`=8, `LOCK_TIMEOUT`=100, `PLLRST_CYCLES`=4.
- Locked high from reset release → `rst_n_o`,`ready_o` rise after edge 26; `loss_cnt_o`=0, `pll_rst_o` never high.
- Locked toggles low for 1 cycle at stable count 10 → `stab_cnt` restarts; `rst_n_o` rises 16+8 edges after the glitch is cleared from `lock_s`.
- Locked held low → `pll_rst_o` high after edge 100 for 4 cycles, `retry_cnt_o`=1; repeats, saturating at 15 after 16+ timeouts.
- In RUN, drop locked for 3 cycles → `rst_n_o` low 2 edges later, `loss_cnt_o`=1; reacquires after 26 edges from locked returning.
- 300 loss events → `loss_cnt_o` holds 255.
- `rst_n` asserted while in HOLD and while in PLLRST → all outputs at reset values immediately, `pll_rst_o` drops without completing the pulse.
